// File: rtl/cache_axi_bridge.sv
// Bridges the cache miss/uncached port onto AXI4: one read and one write burst in flight,
// with reads to the line of an unfinished write held until its B response.
module cache_axi_bridge #(
    parameter int         WIDTH  = 16,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req,
    input  logic [2:0]         rd_type,
    input  logic [31:0]        rd_addr,
    output logic               rd_rdy,
    output logic               ret_valid,
    output logic               ret_last,
    output logic [31:0]        ret_data,
    input  logic               wr_req,
    input  logic [2:0]         wr_type,
    input  logic [31:0]        wr_addr,
    input  logic [3:0]         wr_wstrb,
    input  logic [WIDTH*8-1:0] wr_data,
    output logic               wr_rdy,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [31:0]        awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [3:0]         bid,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);
    localparam int         BEATS    = WIDTH / 4;
    localparam int         CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int         LB       = $clog2(WIDTH);
    localparam logic [7:0] LINE_LEN = 8'(BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t            r_rstate;
    logic [31:0]        r_araddr;
    logic [7:0]         r_arlen;
    logic [2:0]         r_arsize;
    logic               r_arvalid;
    logic               r_rready;

    wstate_t            r_wstate;
    logic [31:0]        r_waddr;
    logic               r_wline;
    logic [7:0]         r_awlen;
    logic [2:0]         r_awsize;
    logic [3:0]         r_wstrb;
    logic [WIDTH*8-1:0] r_wbuf;
    logic [CW-1:0]      r_wcnt;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;

    logic               w_wpend;
    logic               w_wlast;
    logic [CW-1:0]      w_widx;
    logic               w_unused;

    assign w_unused = ^{rid, rresp, bid, bresp};

    // Hazard compare sees the buffer as it was before any write accepted this cycle.
    assign w_wpend = (r_wstate != W_IDLE);
    assign rd_rdy  = (r_rstate == R_IDLE) && !(w_wpend && (rd_addr[31:LB] == r_waddr[31:LB]));
    assign wr_rdy  = (r_wstate == W_IDLE);

    assign arid      = AXI_ID;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arburst   = 2'b01;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign ret_valid = r_rready && rvalid;
    assign ret_last  = r_rready && rvalid && rlast;
    assign ret_data  = rdata;

    assign w_wlast = (8'(r_wcnt) == r_awlen);
    assign w_widx  = r_wline ? r_wcnt : r_waddr[2 +: CW];

    assign awid    = AXI_ID;
    assign awaddr  = r_waddr;
    assign awlen   = r_awlen;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awvalid = r_awvalid;
    assign wdata   = r_wbuf[w_widx*32 +: 32];
    assign wstrb   = r_wline ? 4'hf : r_wstrb;
    assign wlast   = w_wlast;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (rd_req && rd_rdy) begin
                    r_araddr  <= rd_addr;
                    r_arlen   <= (rd_type == 3'b100) ? LINE_LEN : 8'd0;
                    r_arsize  <= (rd_type == 3'b100) ? 3'b010 : {1'b0, rd_type[1:0]};
                    r_arvalid <= 1'b1;
                    r_rstate  <= R_AR;
                end
                R_AR: if (arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (rvalid && rlast) begin
                    r_rready <= 1'b0;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wline   <= 1'b0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_wstrb   <= '0;
            r_wbuf    <= '0;
            r_wcnt    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (wr_req) begin
                    r_waddr   <= wr_addr;
                    r_wline   <= (wr_type == 3'b100);
                    r_awlen   <= (wr_type == 3'b100) ? LINE_LEN : 8'd0;
                    r_awsize  <= (wr_type == 3'b100) ? 3'b010 : {1'b0, wr_type[1:0]};
                    r_wstrb   <= wr_wstrb;
                    r_wbuf    <= wr_data;
                    r_wcnt    <= '0;
                    r_awvalid <= 1'b1;
                    r_wstate  <= W_AW;
                end
                W_AW: if (awready) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (wready) begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_wlast) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (bvalid) begin
                    r_bready <= 1'b0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge; the bench plays the AXI slave by hand.
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready, awvalid, awready;
    logic [3:0]   rid, bid;
    logic [31:0]  rdata, wdata;
    logic [1:0]   rresp, bresp;
    logic         rlast, rvalid, rready;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready, bvalid, bready;

    int ntests = 0;
    int nfail  = 0;

    cache_axi_bridge #(.WIDTH(16), .AXI_ID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        ntests++; if (rd_rdy !== 1'b1) begin nfail++; $display("FAIL rst_rd_rdy: got %b want 1", rd_rdy); end
        ntests++; if (wr_rdy !== 1'b1) begin nfail++; $display("FAIL rst_wr_rdy: got %b want 1", wr_rdy); end
        ntests++; if ({arvalid, rready, awvalid, wvalid, bready, ret_valid} !== 6'b0) begin
            nfail++; $display("FAIL rst_valids: got %b want 000000", {arvalid, rready, awvalid, wvalid, bready, ret_valid}); end
        ntests++; if ({araddr, arlen, awaddr, awlen} !== 80'b0) begin
            nfail++; $display("FAIL rst_regs: araddr %h arlen %0d awaddr %h awlen %0d want 0", araddr, arlen, awaddr, awlen); end
    endtask

    task automatic test_line_read();
        int beat = 0;
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C000040;
        #1;
        ntests++; if (rd_rdy !== 1'b1) begin nfail++; $display("FAIL lr_rdy_idle: got %b want 1", rd_rdy); end
        tick();
        rd_req = 1'b0;
        #1;
        ntests++; if (rd_rdy !== 1'b0) begin nfail++; $display("FAIL lr_rdy_busy: got %b want 0", rd_rdy); end
        ntests++; if (arvalid !== 1'b1) begin nfail++; $display("FAIL lr_arvalid: got %b want 1", arvalid); end
        ntests++; if (araddr !== 32'h1C000040) begin nfail++; $display("FAIL lr_araddr: got %h want 1c000040", araddr); end
        ntests++; if (arlen !== 8'd3) begin nfail++; $display("FAIL lr_arlen: got %0d want 3", arlen); end
        ntests++; if (arsize !== 3'd2) begin nfail++; $display("FAIL lr_arsize: got %0d want 2", arsize); end
        ntests++; if (arburst !== 2'd1 || arid !== 4'd0) begin nfail++; $display("FAIL lr_arburst_id: got %0d/%0d want 1/0", arburst, arid); end
        tick();
        ntests++; if (arvalid !== 1'b1 || araddr !== 32'h1C000040) begin
            nfail++; $display("FAIL lr_ar_hold: got %b %h want 1 1c000040", arvalid, araddr); end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        ntests++; if (arvalid !== 1'b0 || rready !== 1'b1) begin
            nfail++; $display("FAIL lr_r_phase: arvalid %b rready %b want 0 1", arvalid, rready); end
        for (int c = 0; c < 5; c++) begin
            rvalid = (c != 2);
            rdata  = 32'hA0 + beat;
            rlast  = rvalid && (beat == 3);
            #1;
            ntests++; if (ret_valid !== rvalid) begin nfail++; $display("FAIL lr_ret_valid c%0d: got %b want %b", c, ret_valid, rvalid); end
            if (rvalid) begin
                ntests++; if (ret_data !== 32'hA0 + beat) begin nfail++; $display("FAIL lr_ret_data b%0d: got %h want %h", beat, ret_data, 32'hA0 + beat); end
                ntests++; if (ret_last !== (beat == 3)) begin nfail++; $display("FAIL lr_ret_last b%0d: got %b want %b", beat, ret_last, beat == 3); end
            end
            ntests++; if (rd_rdy !== 1'b0) begin nfail++; $display("FAIL lr_rdy_burst c%0d: got %b want 0", c, rd_rdy); end
            tick();
            if (rvalid) beat++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        ntests++; if (rd_rdy !== 1'b1 || rready !== 1'b0) begin
            nfail++; $display("FAIL lr_done: rd_rdy %b rready %b want 1 0", rd_rdy, rready); end
    endtask

    task automatic test_byte_read();
        rd_req = 1'b1; rd_type = 3'b000; rd_addr = 32'hBFAF8003;
        tick();
        rd_req = 1'b0; arready = 1'b1;
        #1;
        ntests++; if (araddr !== 32'hBFAF8003) begin nfail++; $display("FAIL br_araddr: got %h want bfaf8003", araddr); end
        ntests++; if (arlen !== 8'd0 || arsize !== 3'd0) begin nfail++; $display("FAIL br_len_size: got %0d/%0d want 0/0", arlen, arsize); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h00000055;
        #1;
        ntests++; if (ret_valid !== 1'b1 || ret_last !== 1'b1 || ret_data !== 32'h55) begin
            nfail++; $display("FAIL br_beat: got v%b l%b %h want v1 l1 00000055", ret_valid, ret_last, ret_data); end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        ntests++; if (rd_rdy !== 1'b1) begin nfail++; $display("FAIL br_done: got %b want 1", rd_rdy); end
    endtask

    task automatic test_line_write();
        logic [31:0] exp_w [4] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        int k = 0;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00001230; wr_wstrb = 4'h1;
        wr_data = 128'h33333333_22222222_11111111_00000000;
        tick();
        wr_req = 1'b0;
        #1;
        ntests++; if (wr_rdy !== 1'b0 || awvalid !== 1'b1) begin nfail++; $display("FAIL lw_aw: wr_rdy %b awvalid %b want 0 1", wr_rdy, awvalid); end
        ntests++; if (awaddr !== 32'h1230 || awlen !== 8'd3 || awsize !== 3'd2 || awburst !== 2'd1) begin
            nfail++; $display("FAIL lw_aw_fields: got %h %0d %0d %0d want 00001230 3 2 1", awaddr, awlen, awsize, awburst); end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        for (int c = 0; c < 16 && k < 4; c++) begin
            wready = c[0];
            #1;
            ntests++; if (wvalid !== 1'b1) begin nfail++; $display("FAIL lw_wvalid c%0d: got %b want 1", c, wvalid); end
            if (wvalid && wready) begin
                ntests++; if (wdata !== exp_w[k]) begin nfail++; $display("FAIL lw_wdata b%0d: got %h want %h", k, wdata, exp_w[k]); end
                ntests++; if (wstrb !== 4'hf) begin nfail++; $display("FAIL lw_wstrb b%0d: got %h want f", k, wstrb); end
                ntests++; if (wlast !== (k == 3)) begin nfail++; $display("FAIL lw_wlast b%0d: got %b want %b", k, wlast, k == 3); end
                k++;
            end
            tick();
        end
        wready = 1'b0;
        ntests++; if (k !== 4) begin nfail++; $display("FAIL lw_beats: got %0d want 4", k); end
        #1;
        ntests++; if (wvalid !== 1'b0 || bready !== 1'b1 || wr_rdy !== 1'b0) begin
            nfail++; $display("FAIL lw_resp: wvalid %b bready %b wr_rdy %b want 0 1 0", wvalid, bready, wr_rdy); end
        tick();
        ntests++; if (wr_rdy !== 1'b0) begin nfail++; $display("FAIL lw_wait_b: got %b want 0", wr_rdy); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        ntests++; if (wr_rdy !== 1'b1 || bready !== 1'b0) begin nfail++; $display("FAIL lw_done: wr_rdy %b bready %b want 1 0", wr_rdy, bready); end
    endtask

    task automatic test_word_store();
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'hBFAF8008; wr_wstrb = 4'h3;
        wr_data = 128'h44444444_DEADBEEF_22222222_11111111;
        tick();
        wr_req = 1'b0; awready = 1'b1;
        #1;
        ntests++; if (awaddr !== 32'hBFAF8008 || awlen !== 8'd0 || awsize !== 3'd2) begin
            nfail++; $display("FAIL ws_aw: got %h %0d %0d want bfaf8008 0 2", awaddr, awlen, awsize); end
        tick();
        awready = 1'b0; wready = 1'b1;
        #1;
        ntests++; if (wvalid !== 1'b1 || wdata !== 32'hDEADBEEF || wstrb !== 4'h3 || wlast !== 1'b1) begin
            nfail++; $display("FAIL ws_beat: got v%b %h s%h l%b want v1 deadbeef s3 l1", wvalid, wdata, wstrb, wlast); end
        tick();
        wready = 1'b0; bvalid = 1'b1;
        #1;
        ntests++; if (bready !== 1'b1 || wvalid !== 1'b0) begin nfail++; $display("FAIL ws_resp: bready %b wvalid %b want 1 0", bready, wvalid); end
        tick();
        bvalid = 1'b0;
        #1;
        ntests++; if (wr_rdy !== 1'b1) begin nfail++; $display("FAIL ws_done: got %b want 1", wr_rdy); end
    endtask

    task automatic test_hazard();
        int nb = 0;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00001230; wr_wstrb = 4'h0;
        wr_data = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h00001234;
        #1;
        ntests++; if (rd_rdy !== 1'b0) begin nfail++; $display("FAIL hz_block: got %b want 0", rd_rdy); end
        tick();
        ntests++; if (rd_rdy !== 1'b0 || arvalid !== 1'b0) begin nfail++; $display("FAIL hz_block2: rd_rdy %b arvalid %b want 0 0", rd_rdy, arvalid); end
        rd_addr = 32'h00002000;
        #1;
        ntests++; if (rd_rdy !== 1'b1) begin nfail++; $display("FAIL hz_other_line: got %b want 1", rd_rdy); end
        tick();
        rd_req = 1'b0;
        #1;
        ntests++; if (arvalid !== 1'b1 || araddr !== 32'h2000 || awvalid !== 1'b1) begin
            nfail++; $display("FAIL hz_other_ar: arvalid %b araddr %h awvalid %b want 1 00002000 1", arvalid, araddr, awvalid); end
        arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h77;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h00001234; awready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b1;
        #1;
        for (int c = 0; c < 8 && wvalid; c++) begin
            ntests++; if (rd_rdy !== 1'b0) begin nfail++; $display("FAIL hz_wdata_block c%0d: got %b want 0", c, rd_rdy); end
            nb++;
            tick();
        end
        wready = 1'b0;
        ntests++; if (nb !== 4) begin nfail++; $display("FAIL hz_beats: got %0d want 4", nb); end
        ntests++; if (bready !== 1'b1 || rd_rdy !== 1'b0) begin nfail++; $display("FAIL hz_resp: bready %b rd_rdy %b want 1 0", bready, rd_rdy); end
        bvalid = 1'b1;
        #1;
        ntests++; if (rd_rdy !== 1'b0) begin nfail++; $display("FAIL hz_b_cycle: got %b want 0", rd_rdy); end
        tick();
        bvalid = 1'b0;
        #1;
        ntests++; if (rd_rdy !== 1'b1) begin nfail++; $display("FAIL hz_release: got %b want 1", rd_rdy); end
        tick();
        rd_req = 1'b0;
        #1;
        ntests++; if (arvalid !== 1'b1 || araddr !== 32'h1234 || arlen !== 8'd0) begin
            nfail++; $display("FAIL hz_late_ar: arvalid %b araddr %h arlen %0d want 1 00001234 0", arvalid, araddr, arlen); end
        arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00004000;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C000080;
        tick();
        rd_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hB0;
        tick();
        rdata = 32'hB1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        ntests++; if (arvalid !== 1'b0 || rready !== 1'b0 || ret_valid !== 1'b0) begin
            nfail++; $display("FAIL rm_read: arvalid %b rready %b ret_valid %b want 0 0 0", arvalid, rready, ret_valid); end
        ntests++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1 || awvalid !== 1'b0) begin
            nfail++; $display("FAIL rm_rdy: rd_rdy %b wr_rdy %b awvalid %b want 1 1 0", rd_rdy, wr_rdy, awvalid); end
        rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rid = 4'h5; rdata = '0; rresp = 2'b10; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'h6; bresp = 2'b11; bvalid = 1'b0;
        test_reset();
        test_line_read();
        test_byte_read();
        test_line_write();
        test_word_store();
        test_hazard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
